// File: rtl/axi_master_wrapper_pkg.sv
// Shared AXI definitions for the master wrapper: bus widths, encodings and FSM states.
// Width/encoding macros are guarded so an existing AXI_define.svh takes precedence.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_SIZE_WORD
`define AXI_SIZE_WORD 3'b010
`endif
`ifndef AXI_BURST_INC
`define AXI_BURST_INC 2'b01
`endif
`ifndef AXI_RESP_OKAY
`define AXI_RESP_OKAY 2'b00
`endif
`ifndef AXI_RESP_SLVERR
`define AXI_RESP_SLVERR 2'b10
`endif

package axi_master_wrapper_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    localparam logic [2:0] SIZE_WORD   = `AXI_SIZE_WORD;
    localparam logic [1:0] BURST_INCR  = `AXI_BURST_INC;
    localparam logic [1:0] RESP_OKAY   = `AXI_RESP_OKAY;
    localparam logic [1:0] RESP_SLVERR = `AXI_RESP_SLVERR;

endpackage

// File: rtl/axi_master_wrapper.sv
// Single-outstanding AXI initiator: one local burst request becomes one AR+R or AW+W+B transaction.
// Optional response checking (sticky err) is enabled by defining AXI_MASTER_RESP_CHK_EN.
module axi_master_wrapper
    import axi_master_wrapper_pkg::*;
#(
    parameter logic [`AXI_ID_BITS-1:0] ID = 4'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [`AXI_ADDR_BITS-1:0] req_addr,
    input  logic [`AXI_LEN_BITS-1:0]  req_len,
    input  logic [`AXI_DATA_BITS-1:0] wr_data,
    input  logic [`AXI_STRB_BITS-1:0] wr_strb,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic [`AXI_DATA_BITS-1:0] rd_data,
    output logic                      rd_valid,
    output logic                      done,
    output logic                      err,
    output logic [`AXI_ID_BITS-1:0]   awid,
    output logic [`AXI_ADDR_BITS-1:0] awaddr,
    output logic [`AXI_LEN_BITS-1:0]  awlen,
    output logic [2:0]                awsize,
    output logic [1:0]                awburst,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [`AXI_DATA_BITS-1:0] wdata,
    output logic [`AXI_STRB_BITS-1:0] wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [`AXI_ID_BITS-1:0]   bid,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [`AXI_ID_BITS-1:0]   arid,
    output logic [`AXI_ADDR_BITS-1:0] araddr,
    output logic [`AXI_LEN_BITS-1:0]  arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [`AXI_ID_BITS-1:0]   rid,
    input  logic [`AXI_DATA_BITS-1:0] rdata,
    input  logic [1:0]                rresp,
    input  logic                      rlast,
    input  logic                      rvalid,
    output logic                      rready
);

    state_t                    state_q, state_d;
    logic [`AXI_ADDR_BITS-1:0] addr_q;
    logic [`AXI_LEN_BITS-1:0]  len_q;
    logic [`AXI_LEN_BITS-1:0]  cnt_q;
    logic                      accept;

    assign accept = (state_q == S_IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        arvalid   = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        wr_ready  = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_write ? S_AW : S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    rd_valid = 1'b1;
                    // rlast alone ends the read, even if the beat count disagrees
                    if (rlast) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = S_W;
            end
            S_W: begin
                wvalid = wr_valid;
                wlast  = (cnt_q == len_q);
                if (wr_valid && wready) begin
                    wr_ready = 1'b1;
                    if (cnt_q == len_q) state_d = S_B;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            addr_q <= {req_addr[`AXI_ADDR_BITS-1:2], 2'b00};
            len_q  <= req_len;
            cnt_q  <= '0;
        end else if (rd_valid || wr_ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = SIZE_WORD;
    assign arburst = BURST_INCR;
    assign arid    = ID;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = SIZE_WORD;
    assign awburst = BURST_INCR;
    assign awid    = ID;
    assign wdata   = wr_data;
    assign wstrb   = wr_strb;
    assign rd_data = rdata;

`ifdef AXI_MASTER_RESP_CHK_EN
    logic err_q;
    logic unused_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state_q == S_R && rvalid &&
                      (rresp != RESP_OKAY || (rlast && cnt_q != len_q))) ||
                     (state_q == S_B && bvalid && bresp != RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign err         = err_q;
    assign unused_bits = ^{rid, bid, req_addr[1:0]};
`else
    logic unused_bits;

    assign err         = 1'b0;
    assign unused_bits = ^{rid, bid, req_addr[1:0], rresp, bresp};
`endif

endmodule

// File: tb/tb_axi_master_wrapper.sv
// Directed self-checking bench for axi_master_wrapper; the AXI slave side is driven by the tasks below.
module tb_axi_master_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, done, err;
    logic [3:0]  awid, awlen, arid, arlen, bid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef AXI_MASTER_RESP_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    axi_master_wrapper #(.ID(4'h0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++;
        if ({arvalid, awvalid, wvalid, wlast, rready, bready} !== 6'b0) begin
            n_bad++; $display("FAIL reset_axi_ctrl: got %b want 000000", {arvalid, awvalid, wvalid, wlast, rready, bready});
        end
        n_cmp++;
        if ({rd_valid, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {rd_valid, done, err}); end
        n_cmp++;
        if (araddr !== 32'h0 || arlen !== 4'h0) begin n_bad++; $display("FAIL reset_fields: got %h/%h want 0/0", araddr, arlen); end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_read;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0043; req_len = 4'd3;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_accept_ready: got %b want 1", req_ready); end
        next_cycle();
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== 32'h40 || arlen !== 4'd3) begin
            n_bad++; $display("FAIL rd_ar_fields: got v=%b a=%h l=%0d want v=1 a=40 l=3", arvalid, araddr, arlen);
        end
        n_cmp++;
        if (arsize !== 3'b010 || arburst !== 2'b01 || arid !== 4'h0) begin
            n_bad++; $display("FAIL rd_ar_attr: got size=%b burst=%b id=%h want 010 01 0", arsize, arburst, arid);
        end
        next_cycle();
        arready = 1'b1;
        #1;
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== 32'h40) begin
            n_bad++; $display("FAIL rd_ar_hold: got v=%b a=%h want v=1 a=40", arvalid, araddr);
        end
        next_cycle();
        arready = 1'b0;
        #1;
        n_cmp++;
        if (arvalid !== 1'b0 || rready !== 1'b1 || rd_valid !== 1'b0) begin
            n_bad++; $display("FAIL rd_r_entry: got arv=%b rr=%b rdv=%b want 0 1 0", arvalid, rready, rd_valid);
        end
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = 32'hA0 + 32'(i); rlast = (i == 3);
            #1;
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + 32'(i) || done !== (i == 3)) begin
                n_bad++; $display("FAIL rd_beat%0d: got v=%b d=%h done=%b want v=1 d=%h done=%b",
                                  i, rd_valid, rd_data, done, 32'hA0 + 32'(i), (i == 3));
            end
            next_cycle();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || rd_valid !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL rd_return_idle: got rdy=%b rdv=%b done=%b want 1 0 0", req_ready, rd_valid, done);
        end
    endtask

    task automatic test_write_single;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0100; req_len = 4'd0;
        next_cycle();
        req_valid = 1'b0; awready = 1'b1;
        #1;
        n_cmp++;
        if (awvalid !== 1'b1 || awaddr !== 32'h100 || awlen !== 4'd0 || awsize !== 3'b010 || awburst !== 2'b01 || awid !== 4'h0) begin
            n_bad++; $display("FAIL wr1_aw: got v=%b a=%h l=%0d s=%b b=%b want 1 100 0 010 01", awvalid, awaddr, awlen, awsize, awburst);
        end
        next_cycle();
        awready = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; wr_strb = 4'b0011; wready = 1'b1;
        #1;
        n_cmp++;
        if (wvalid !== 1'b1 || wlast !== 1'b1 || wstrb !== 4'b0011 || wdata !== 32'hDEAD_BEEF || wr_ready !== 1'b1) begin
            n_bad++; $display("FAIL wr1_beat: got v=%b last=%b strb=%b d=%h rdy=%b want 1 1 0011 deadbeef 1",
                              wvalid, wlast, wstrb, wdata, wr_ready);
        end
        next_cycle();
        wr_valid = 1'b0; wready = 1'b0;
        #1;
        n_cmp++;
        if (bready !== 1'b1 || wvalid !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL wr1_b_wait: got br=%b wv=%b done=%b want 1 0 0", bready, wvalid, done);
        end
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL wr1_done: got %b want 1", done); end
        next_cycle();
        bvalid = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL wr1_idle: got rdy=%b done=%b err=%b want 1 0 0", req_ready, done, err);
        end
    endtask

    task automatic test_write_toggle;
        int beats = 0;
        int cyc = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0200; req_len = 4'd15;
        next_cycle();
        req_valid = 1'b0; awready = 1'b1;
        next_cycle();
        awready = 1'b0;
        while (beats < 16 && cyc < 64) begin
            wr_valid = 1'b1; wr_data = 32'h1000 + 32'(beats); wr_strb = 4'hF; wready = (cyc % 2 == 1);
            #1;
            n_cmp++;
            if (wvalid !== 1'b1 || wr_ready !== wready || wlast !== (beats == 15) || wdata !== 32'h1000 + 32'(beats)) begin
                n_bad++; $display("FAIL wr16_cyc%0d: got wv=%b rdy=%b last=%b d=%h want 1 %b %b %h",
                                  cyc, wvalid, wr_ready, wlast, wdata, wready, (beats == 15), 32'h1000 + 32'(beats));
            end
            if (wready) beats++;
            next_cycle();
            cyc++;
        end
        n_cmp++;
        if (beats != 16) begin n_bad++; $display("FAIL wr16_timeout: got %0d beats want 16", beats); end
        wr_valid = 1'b0; wready = 1'b0;
        #1;
        n_cmp++;
        if (bready !== 1'b1 || wvalid !== 1'b0) begin n_bad++; $display("FAIL wr16_b_state: got br=%b wv=%b want 1 0", bready, wvalid); end
        bvalid = 1'b1;
        #1;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL wr16_done: got %b want 1", done); end
        next_cycle();
        bvalid = 1'b0;
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0080; req_len = 4'd0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first_ready: got %b want 1", req_ready); end
        next_cycle();
        #1;
        n_cmp++;
        if (req_ready !== 1'b0 || arvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_ar: got rdy=%b arv=%b want 0 1", req_ready, arvalid); end
        arready = 1'b1;
        next_cycle();
        arready = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_r_ready: got %b want 0", req_ready); end
        rvalid = 1'b1; rlast = 1'b1; rdata = 32'h55;
        #1;
        n_cmp++;
        if (done !== 1'b1 || req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_done: got done=%b rdy=%b want 1 0", done, req_ready); end
        next_cycle();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_reaccept: got %b want 1", req_ready); end
        next_cycle();
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if (arvalid !== 1'b1 || araddr !== 32'h80) begin n_bad++; $display("FAIL b2b_second_ar: got v=%b a=%h want 1 80", arvalid, araddr); end
        arready = 1'b1;
        next_cycle();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        #1;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done: got %b want 1", done); end
        next_cycle();
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_resp_err;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0500; req_len = 4'd0;
        next_cycle();
        req_valid = 1'b0; awready = 1'b1;
        next_cycle();
        awready = 1'b0; wr_valid = 1'b1; wready = 1'b1; wr_data = 32'h1234_5678; wr_strb = 4'hF;
        next_cycle();
        wr_valid = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10;
        #1;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL err_b_done: got %b want 1", done); end
        next_cycle();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        n_cmp++;
        if (err !== ERR_EXP) begin n_bad++; $display("FAIL err_slverr: got %b want %b", err, ERR_EXP); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0300; req_len = 4'd3;
        next_cycle();
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_accept: got %b want 0", err); end
        arready = 1'b1;
        next_cycle();
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b0; rdata = 32'hB0;
        next_cycle();
        rlast = 1'b1; rdata = 32'hB1;
        #1;
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL err_early_rlast_done: got %b want 1", done); end
        next_cycle();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_cmp++;
        if (err !== ERR_EXP || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL err_early_rlast: got err=%b rdy=%b want %b 1", err, req_ready, ERR_EXP);
        end
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0400; req_len = 4'd3;
        next_cycle();
        req_valid = 1'b0; awready = 1'b1;
        next_cycle();
        awready = 1'b0; wr_valid = 1'b1; wready = 1'b1; wr_data = 32'hC0; wr_strb = 4'hF;
        next_cycle();
        wr_data = 32'hC1;
        #1;
        n_cmp++;
        if (wvalid !== 1'b1 || wlast !== 1'b0) begin n_bad++; $display("FAIL rstmid_beat2: got wv=%b last=%b want 1 0", wvalid, wlast); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || wr_ready !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_drop: got awv=%b wv=%b wrdy=%b rdy=%b want 0 0 0 1", awvalid, wvalid, wr_ready, req_ready);
        end
        next_cycle();
        rst = 1'b0; wr_valid = 1'b0; wready = 1'b0;
        next_cycle();
        #1;
        n_cmp++;
        if (req_ready !== 1'b1 || awvalid !== 1'b0 || err !== 1'b0 || awaddr !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_idle: got rdy=%b awv=%b err=%b a=%h want 1 0 0 0", req_ready, awvalid, err, awaddr);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        next_cycle();
        test_write_single();
        next_cycle();
        test_write_toggle();
        next_cycle();
        test_back_to_back();
        next_cycle();
        test_resp_err();
        next_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
